serial_subtractor_2bit: RTL
===========================

Name: serial_subtractor_2bit

Overview:
- Multi-cycle subtractor: computes diff = a - b - bin over WIDTH bits, resolving 2 bits per clock with a registered borrow chain.
- Companion to the 2-bit full adder. Bit-serial arithmetic primitive for PIM synthesis experiments, with valid/ready handshakes on operand input and result output.

Parameters:
- WIDTH, 8, operand/result width; must be even and >= 2. Number of digit steps N = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_valid  input  1  operands present
- start_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, sampled on accept
- b  input  WIDTH  subtrahend, sampled on accept
- bin  input  1  borrow-in, sampled on accept
- done_valid  output  1  result valid
- done_ready  input  1  consumer takes result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out (1 = unsigned underflow)

Behaviour:
- Reset (async, active-high):
  - state=IDLE, step counter=0, borrow=0, operand and diff registers=0.
  - Outputs during/after reset: start_ready=1, done_valid=0, diff=0, bout=0.
- State machine has three states: IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - Accept when start_valid & start_ready. Latch a, b; borrow<=bin; idx<=0; go to RUN.
- RUN:
  - start_ready=0; start_valid is ignored.
  - Each edge processes bit pair [2*idx+1:2*idx] as a ripple of two borrow cells.
  - Per bit: d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br).
  - Write the 2 result bits into diff[2*idx+1:2*idx]; borrow<=carry out of the pair.
  - On idx = N-1: bout<=final borrow; go to DONE. Otherwise idx<=idx+1.
- Latency: done_valid rises exactly N rising edges after the accepting edge (4 for WIDTH=8).
- DONE:
  - done_valid=1; diff and bout are held stable. start_ready=0.
  - On done_valid & done_ready: go to IDLE; diff and bout keep their values until the next accept.
  - Unbounded done_ready low: hold indefinitely, no data loss.
- No overlap: a new accept only occurs in IDLE, so there is a minimum of one idle cycle between operations.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. A partial result is never presented.
- Unsigned results wrap modulo 2^WIDTH; bout flags unsigned a < b + bin.
- diff bits not yet computed during RUN hold 0 (cleared on accept). The bench must not sample diff before done_valid.

Optional Feature:
- Macro SUB_OVERFLOW_EN.
- When defined, the block adds output port ovf (1 bit), registered alongside bout and reset to 0.
  - ovf = signed two's-complement overflow of the final result: (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]).
  - Held with diff in DONE.
- When not defined, port ovf and its logic do not exist. All other behaviour is identical.

Test Plan (WIDTH=8):
1. a=0x5A, b=0x3C, bin=0 -> done_valid 4 edges after accept; diff=0x1E, bout=0 (ovf=0).
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
3. With SUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
4. Backpressure: hold done_ready=0 for 10 cycles after done_valid -> done_valid stays 1, diff/bout stable, start_ready=0. Raise done_ready -> IDLE next edge, start_ready=1.
5. Change a/b and pulse start_valid during RUN -> ignored; result still matches originally latched operands.
6. Assert rst at step idx=2 of a=0xFF, b=0x01 -> immediately done_valid=0, diff=0, bout=0, start_ready=1. A subsequent clean operation a=0xFF, b=0x01 gives diff=0xFE, bout=0.

Source files
------------

// File: rtl/serial_subtractor_2bit.sv
// Multi-cycle subtractor: diff = a - b - bin, two bits per clock through a registered borrow chain.
// Optional signed-overflow output ovf is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_2bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Borrow cell: returns {br_next, d}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic br);
    logic d;
    logic br_next;
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    return {br_next, d};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             start_ready_q, start_ready_d;
  logic             done_valid_q, done_valid_d;

  logic [IDXW:0]    pos_s;
  logic [1:0]       a_pair_s;
  logic [1:0]       b_pair_s;
  logic [1:0]       lo_s;
  logic [1:0]       hi_s;

  assign pos_s    = {idx_q, 1'b0};
  assign a_pair_s = a_q[pos_s +: 2];
  assign b_pair_s = b_q[pos_s +: 2];
  assign lo_s     = sub_cell(a_pair_s[0], b_pair_s[0], br_q);
  assign hi_s     = sub_cell(a_pair_s[1], b_pair_s[1], lo_s[1]);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    br_d          = br_q;
    diff_d        = diff_q;
    bout_d        = bout_q;
    ovf_d         = ovf_q;
    start_ready_d = start_ready_q;
    done_valid_d  = done_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d           = a;
          b_d           = b;
          br_d          = bin;
          idx_d         = '0;
          diff_d        = '0;
          bout_d        = 1'b0;
          ovf_d         = 1'b0;
          start_ready_d = 1'b0;
          state_d       = ST_RUN;
        end else begin
          start_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        diff_d[pos_s +: 2] = {hi_s[0], lo_s[0]};
        br_d               = hi_s[1];
        if (idx_q == IDXW'(N - 1)) begin
          bout_d       = hi_s[1];
          // The pair's high bit is the result MSB on the final step.
          ovf_d        = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (hi_s[0] != a_q[WIDTH-1]);
          done_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          done_valid_d  = 1'b0;
          start_ready_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          done_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        start_ready_d = 1'b1;
        done_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      br_q          <= 1'b0;
      diff_q        <= '0;
      bout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_q           <= a_d;
      b_q           <= b_d;
      br_q          <= br_d;
      diff_q        <= diff_d;
      bout_q        <= bout_d;
      ovf_q         <= ovf_d;
      start_ready_q <= start_ready_d;
      done_valid_q  <= done_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign done_valid  = done_valid_q;
  assign diff        = diff_q;
  assign bout        = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf         = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule
